f36m_mult: RTL and testbench

- Multiplier for GF(3^{6m}) = GF(3^{3m})[σ]/(σ^2+1).
- Each operand is packed as {x1, x0}, representing x0 + x1·σ, with both halves in GF(3^{3m}).
- Uses a single f33m_mult3 instance to form three Karatsuba products, then combines them with GF(3^{3m}) add/sub.
- Consumes f33m products and sits directly downstream of the f33m multiplier layer; it feeds the Tate-pairing Miller loop and final exponentiation.

---
 rtl/f36m_mult.sv | 253 +++++++++++++++++++++++++
 tb/tb_f36m_mult.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/f36m_mult.sv
// ---------------------------------------------------------------------------
// f36m_mult: multiplier for GF(3^{6m}) = GF(3^{3m})[sigma]/(sigma^2+1).
//
// Contents (in order):
//   f33m_pkg       - coefficient-wise GF(3) helpers for GF(3^{3m}) vectors
//   f33m_add       - GF(3^{3m}) addition
//   f33m_neg       - GF(3^{3m}) negation
//   f33m_mult_lane - one digit-serial GF(3^{3m}) multiplier
//   f33m_mult3     - three lanes sharing one reset/start, sticky done
//   f36m_mult      - top: Karatsuba over GF(3^{3m})
//
// Encoding: each GF(3) coefficient is 2 bits (00=0, 01=1, 10=2).
// Coefficient i of a GF(3^{3m}) vector sits in bits [2i+1:2i].
// GF(3^{3m}) is built as GF(3)[x]/(x^{3m} - x - 1). The default m=1 gives
// x^3 - x - 1, which is irreducible over GF(3).
//
// Top ports:
//   clk   in   1      clock
//   reset in   1      synchronous, active-high; also starts an operation
//   a     in   W6+1   operand {a1,a0} = a0 + a1*sigma, stable until done
//   b     in   W6+1   operand {b1,b0}, stable until done
//   c     out  W6+1   product {c1,c0}, registered, valid while done=1
//   done  out  1      sticky completion flag, cleared by reset
//   busy  out  1      only with F36M_MULT_BUSY_EN: operation in progress
//
// Optional feature macro: F36M_MULT_BUSY_EN adds the registered busy port.
// ---------------------------------------------------------------------------

`ifndef WIDTH
`define WIDTH 1
`endif
`ifndef W3
`define W3 (3*(`WIDTH+1)-1)
`endif
`ifndef W6
`define W6 (2*(`W3+1)-1)
`endif

package f33m_pkg;
  localparam int TRITS = (`W3 + 1) / 2;

  function automatic logic [1:0] tritAdd(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [`W3:0] vecAdd(input logic [`W3:0] x, input logic [`W3:0] y);
    logic [`W3:0] r;
    r = '0;
    for (int i = 0; i < TRITS; i++) r[2*i +: 2] = tritAdd(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  // Negating a coefficient swaps the codes for 1 and 2, i.e. swaps the bits.
  function automatic logic [`W3:0] vecNeg(input logic [`W3:0] x);
    logic [`W3:0] r;
    r = '0;
    for (int i = 0; i < TRITS; i++) r[2*i +: 2] = {x[2*i], x[2*i+1]};
    return r;
  endfunction

  // Multiply by x and fold x^{3m} back as x + 1.
  function automatic logic [`W3:0] mulX(input logic [`W3:0] x);
    logic [`W3:0] r;
    logic [1:0]   top;
    top    = x[`W3 -: 2];
    r      = {x[`W3-2:0], 2'b00};
    r[1:0] = tritAdd(r[1:0], top);
    r[3:2] = tritAdd(r[3:2], top);
    return r;
  endfunction

  function automatic logic [`W3:0] scaleTrit(input logic [`W3:0] x, input logic [1:0] t);
    logic [`W3:0] r;
    case (t)
      2'b01:   r = x;
      2'b10:   r = vecNeg(x);
      default: r = '0;
    endcase
    return r;
  endfunction
endpackage

module f33m_add
  import f33m_pkg::*;
(
  input  logic [`W3:0] a,
  input  logic [`W3:0] b,
  output logic [`W3:0] c
);
  assign c = vecAdd(a, b);
endmodule

module f33m_neg
  import f33m_pkg::*;
(
  input  logic [`W3:0] a,
  output logic [`W3:0] c
);
  assign c = vecNeg(a);
endmodule

module f33m_mult_lane
  import f33m_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [`W3:0] a,
  input  logic [`W3:0] b,
  output logic [`W3:0] p,
  output logic         done
);
  localparam int CW = $clog2(TRITS + 1);

  logic [`W3:0]  acc_q;
  logic [`W3:0]  bSh_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  // Horner evaluation, most significant coefficient of b first: one
  // coefficient per cycle, so the product is ready TRITS cycles after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      bSh_q  <= b;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      acc_q <= vecAdd(mulX(acc_q), scaleTrit(a, bSh_q[`W3 -: 2]));
      bSh_q <= {bSh_q[`W3-2:0], 2'b00};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(TRITS - 1)) done_q <= 1'b1;
    end
  end

  assign p    = acc_q;
  assign done = done_q;
endmodule

module f33m_mult3 (
  input  logic         clk,
  input  logic         reset,
  input  logic [`W3:0] a0,
  input  logic [`W3:0] b0,
  output logic [`W3:0] c0,
  input  logic [`W3:0] a1,
  input  logic [`W3:0] b1,
  output logic [`W3:0] c1,
  input  logic [`W3:0] a2,
  input  logic [`W3:0] b2,
  output logic [`W3:0] c2,
  output logic         done
);
  logic [2:0] laneDone;

  f33m_mult_lane lane0 (.clk(clk), .reset(reset), .a(a0), .b(b0), .p(c0), .done(laneDone[0]));
  f33m_mult_lane lane1 (.clk(clk), .reset(reset), .a(a1), .b(b1), .p(c1), .done(laneDone[1]));
  f33m_mult_lane lane2 (.clk(clk), .reset(reset), .a(a2), .b(b2), .p(c2), .done(laneDone[2]));

  assign done = &laneDone;
endmodule

module f36m_mult (
  input  logic         clk,
  input  logic         reset,
  input  logic [`W6:0] a,
  input  logic [`W6:0] b,
  output logic [`W6:0] c,
  output logic         done
`ifdef F36M_MULT_BUSY_EN
  ,
  output logic         busy
`endif
);
  typedef enum logic [2:0] {
    RUN = 3'b100,
    CMB = 3'b010,
    FIN = 3'b001
  } state_t;

  state_t       state_q;
  logic         delay1_q, delay2_q;
  logic         done_q;
  logic [`W6:0] c_q;
  logic [`W6:0] c_d;
  logic         subDone;
  logic [`W3:0] sumA, sumB;
  logic [`W3:0] prod0, prod1, prod2;
  logic [`W3:0] negP0, negP1, midSum, res0, res1;

  f33m_add addA (.a(a[`W3:0]), .b(a[`W6:`W3+1]), .c(sumA));
  f33m_add addB (.a(b[`W3:0]), .b(b[`W6:`W3+1]), .c(sumB));

  f33m_mult3 core (
    .clk(clk), .reset(delay2_q),
    .a0(a[`W3:0]),       .b0(b[`W3:0]),       .c0(prod0),
    .a1(a[`W6:`W3+1]),   .b1(b[`W6:`W3+1]),   .c1(prod1),
    .a2(sumA),           .b2(sumB),           .c2(prod2),
    .done(subDone)
  );

  // c0 = P0 - P1, c1 = P2 - P0 - P1 (sigma^2 = -1).
  f33m_neg negU0 (.a(prod0), .c(negP0));
  f33m_neg negU1 (.a(prod1), .c(negP1));
  f33m_add addC0 (.a(prod0), .b(negP1), .c(res0));
  f33m_add addM  (.a(prod2), .b(negP0), .c(midSum));
  f33m_add addC1 (.a(midSum), .b(negP1), .c(res1));

  assign c_d = {res1, res0};

  always_ff @(posedge clk) begin
    delay1_q <= reset;
    delay2_q <= delay1_q;
  end

  // sub_done is sticky and is only cleared once the delayed reset reaches
  // the sub-core, so a stale high from an aborted or finished run is still
  // visible while delay1 or delay2 is set; both are masked here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      done_q  <= 1'b0;
`ifdef F36M_MULT_BUSY_EN
      busy    <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
`ifdef F36M_MULT_BUSY_EN
          busy <= 1'b1;
`endif
          if (subDone && !delay1_q && !delay2_q) state_q <= CMB;
        end
        CMB: begin
          state_q <= FIN;
          c_q     <= c_d;
          done_q  <= 1'b1;
`ifdef F36M_MULT_BUSY_EN
          busy    <= 1'b0;
`endif
        end
        FIN: begin
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign c    = c_q;
  assign done = done_q;
endmodule

// File: tb/tb_f36m_mult.sv
// ---------------------------------------------------------------------------
// tb_f36m_mult: self-checking bench for f36m_mult with the default field
// (m=1: 3 coefficients per GF(3^{3m}) half, 12-bit operands).
// A directed table with hand-computed products, 100 random operands checked
// against an independent schoolbook model, plus reset corner sequences.
// ---------------------------------------------------------------------------
module tb_f36m_mult;
  localparam int TR  = 3;
  localparam int LAT = TR + 4;

  typedef struct {
    string       name;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] a, b;
  logic [11:0] c;
  logic        done;
`ifdef F36M_MULT_BUSY_EN
  logic        busy;
`endif

  int total = 0;
  int bad   = 0;

  f36m_mult dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .done(done)
`ifdef F36M_MULT_BUSY_EN
    , .busy(busy)
`endif
  );

  // free-running clock, outputs sampled on the falling edge
  always #5 clk = ~clk;

  // operands are only allowed to change while reset is high or after done
  logic [11:0] aHeld, bHeld;
  always @(posedge clk) begin
    if (reset) begin
      aHeld <= a;
      bHeld <= b;
    end else if (!done && (a !== aHeld || b !== bHeld)) begin
      $warning("[TB] operands changed before done");
    end
  end

  // schoolbook GF(3)[x]/(x^3 - x - 1) multiply, reduced from the top down
  function automatic logic [5:0] m33Mul(input logic [5:0] x, input logic [5:0] y);
    int p[2*TR-1];
    logic [5:0] r;
    for (int i = 0; i < 2*TR-1; i++) p[i] = 0;
    for (int i = 0; i < TR; i++)
      for (int j = 0; j < TR; j++)
        p[i+j] += int'(x[2*i +: 2]) * int'(y[2*j +: 2]);
    for (int d = 2*TR-2; d >= TR; d--) begin
      p[d-TR]   += p[d];
      p[d-TR+1] += p[d];
      p[d] = 0;
    end
    for (int i = 0; i < TR; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  function automatic logic [5:0] m33Lin(input logic [5:0] x, input logic [5:0] y, input int sgn);
    logic [5:0] r;
    for (int i = 0; i < TR; i++)
      r[2*i +: 2] = 2'((int'(x[2*i +: 2]) + sgn * int'(y[2*i +: 2]) + 3) % 3);
    return r;
  endfunction

  // c0 = a0b0 - a1b1, c1 = a0b1 + a1b0
  function automatic logic [11:0] m36Mul(input logic [11:0] x, input logic [11:0] y);
    logic [5:0] r0, r1;
    r0 = m33Lin(m33Mul(x[5:0], y[5:0]), m33Mul(x[11:6], y[11:6]), -1);
    r1 = m33Lin(m33Mul(x[5:0], y[11:6]), m33Mul(x[11:6], y[5:0]), 1);
    return {r1, r0};
  endfunction

  function automatic logic [11:0] randVec();
    logic [11:0] r;
    for (int i = 0; i < 2*TR; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // called on a falling edge; reset is sampled high on resetCycles rising edges
  task automatic applyStimulus(input logic [11:0] aIn, input logic [11:0] bIn, input int resetCycles);
    a     = aIn;
    b     = bIn;
    reset = 1'b1;
    repeat (resetCycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t tbl[8];
  int   cyc;
  int   cnt;
  logic [11:0] ra, rb, expC;

  initial begin
    tbl[0] = '{"identity",    {6'b000000, 6'b000001}, {6'b100100, 6'b011000}, {6'b100100, 6'b011000}};
    tbl[1] = '{"sigmaSq",     {6'b000001, 6'b000000}, {6'b000001, 6'b000000}, {6'b000000, 6'b000010}};
    tbl[2] = '{"onePlusSgSq", {6'b000001, 6'b000001}, {6'b000001, 6'b000001}, {6'b000010, 6'b000000}};
    tbl[3] = '{"xSq",         {6'b000000, 6'b000100}, {6'b000000, 6'b000100}, {6'b000000, 6'b010000}};
    tbl[4] = '{"xCube",       {6'b000000, 6'b010000}, {6'b000000, 6'b000100}, {6'b000000, 6'b000101}};
    tbl[5] = '{"xSigmaSq",    {6'b000100, 6'b000000}, {6'b000100, 6'b000000}, {6'b000000, 6'b100000}};
    tbl[6] = '{"zeroA",       {6'b000000, 6'b000000}, {6'b011010, 6'b100110}, {6'b000000, 6'b000000}};
    tbl[7] = '{"xFourth",     {6'b000000, 6'b010000}, {6'b000000, 6'b010000}, {6'b000000, 6'b010100}};

    reset = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetDone", 32'(done), 32'd0);

    $display("[TB] directed table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, 1);
      waitDone(cyc);
      checkOutput({tbl[i].name, "Latency"}, 32'(cyc), 32'(LAT));
      checkOutput(tbl[i].name, 32'(c), 32'(tbl[i].c));
    end

    $display("[TB] random operands");
    for (int i = 0; i < 100; i++) begin
      ra = randVec();
      rb = randVec();
      applyStimulus(ra, rb, 1);
      waitDone(cyc);
      checkOutput("randLatency", 32'(cyc), 32'(LAT));
      checkOutput("randProduct", 32'(c), 32'(m36Mul(ra, rb)));
    end
    expC = m36Mul(ra, rb);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done && c === expC) cnt++;
    end
    checkOutput("doneSticky", 32'(cnt), 32'd50);

    $display("[TB] reset mid-operation");
    applyStimulus(randVec(), randVec(), 1);
    repeat (4) @(negedge clk);
    ra = randVec();
    rb = randVec();
    a = ra;
    b = rb;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abortDone", 32'(done), 32'd0);
    reset = 1'b0;
    waitDone(cyc);
    checkOutput("abortLatency", 32'(cyc), 32'(LAT));
    checkOutput("abortProduct", 32'(c), 32'(m36Mul(ra, rb)));

    $display("[TB] reset on the completing edge");
    applyStimulus(randVec(), randVec(), 1);
    repeat (LAT - 1) @(negedge clk);
    ra = randVec();
    rb = randVec();
    a = ra;
    b = rb;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("finResetDone", 32'(done), 32'd0);
    reset = 1'b0;
    waitDone(cyc);
    checkOutput("finResetLatency", 32'(cyc), 32'(LAT));
    checkOutput("finResetProduct", 32'(c), 32'(m36Mul(ra, rb)));

    $display("[TB] done clears on reset");
    a = ra;
    b = rb;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("doneClear", 32'(done), 32'd0);

    $display("[TB] reset held four cycles, zero operand");
    a = '0;
    b = randVec();
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    reset = 1'b0;
    checkOutput("heldResetDone", 32'(cnt), 32'd0);
    waitDone(cyc);
    checkOutput("heldLatency", 32'(cyc), 32'(LAT));
    checkOutput("heldZero", 32'(c), 32'd0);

`ifdef F36M_MULT_BUSY_EN
    $display("[TB] busy flag");
    ra = randVec();
    rb = randVec();
    applyStimulus(ra, rb, 1);
    checkOutput("busyReset", 32'(busy), 32'd0);
    cnt = 0;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy) cnt++;
      if (busy && done) checkOutput("busyAndDone", 32'd1, 32'd0);
    end
    checkOutput("busyCycles", 32'(cnt), 32'(LAT - 1));
    checkOutput("busyAfter", 32'(busy), 32'd0);
    checkOutput("busyProduct", 32'(c), 32'(m36Mul(ra, rb)));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
